// File: rtl/ysyx_22041207_pkg.sv
// Shared definitions for the ysyx_22041207 RV64 core front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_22041207_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // addi x0, x0, 0 -- presented to decode whenever no real instruction is available
    localparam logic [ILEN-1:0] NOP_INST = 32'h00000013;
    localparam logic [XLEN-1:0] RESET_PC = 64'h80000000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_pkt_t;

endpackage : ysyx_22041207_pkg

// File: rtl/ysyx_22041207_ifid_queue.sv
// Show-ahead {pc, inst} queue between instruction fetch and decode.
// Latency: a pair accepted at edge N is visible at the head in the cycle after N (no bypass).
// Backpressure: in_ready drops when full or flushing, independent of out_ready; fetch stalls on ~in_ready.
//
// Ports:
//   clk, rst           core clock, asynchronous active-high reset
//   flush              EX redirect; empties the queue at the next edge, masks both handshakes now
//   in_valid/in_ready  fetch-side handshake carrying in_pc / in_inst
//   out_valid/out_ready decode-side handshake carrying out_pc / out_inst (NOP when empty)
//   count              current occupancy
//   stall_cnt          free-running count of cycles with in_valid && !in_ready
module ysyx_22041207_ifid_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [ILEN-1:0]           in_inst,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [ILEN-1:0]           out_inst,
    output logic [$clog2(DEPTH):0]    count,
    output logic [63:0]               stall_cnt
);
    import ysyx_22041207_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_pkt_t        mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic [63:0]       stall_q,  stall_d;

    logic              push;
    logic              pop;
    fetch_pkt_t        wr_pkt;
    fetch_pkt_t        head_pkt;

    // Handshakes depend only on registered state and flush; a full queue
    // refuses a push even when decode pops in the same cycle.
    assign in_ready  = (count_q < CW'(DEPTH)) && !flush;
    assign out_valid = (count_q != '0) && !flush;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign wr_pkt.pc   = in_pc;
    assign wr_pkt.inst = in_inst;
    assign head_pkt    = mem_q[rd_ptr_q];

    assign out_pc    = out_valid ? head_pkt.pc   : '0;
    assign out_inst  = out_valid ? head_pkt.inst : NOP_INST;
    assign count     = count_q;
    assign stall_cnt = stall_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // push/pop are already masked, so only the pointer/count reset matters
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Counts flush cycles too and is never cleared except by reset.
    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready) stall_d = stall_q + 64'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Entry contents survive a flush; only the pointers make them unreachable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i].pc   <= '0;
                mem_q[i].inst <= NOP_INST;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= wr_pkt;
        end
    end

endmodule : ysyx_22041207_ifid_queue

// File: tb/tb_ysyx_22041207_ifid_queue.sv
module tb_ysyx_22041207_ifid_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [1:0]  count;
    logic [63:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_22041207_ifid_queue #(.DEPTH(2), .XLEN(64), .ILEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [63:0] pc0, input logic [31:0] i0,
                         input logic [63:0] pc1, input logic [31:0] i1);
        in_valid = 1'b1; in_pc = pc0; in_inst = i0;
        tick();
        in_pc = pc1; in_inst = i1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_checks++; if (out_inst !== 32'h00000013) begin n_fail++; $display("FAIL reset_out_inst got %h want 00000013", out_inst); end
        n_checks++; if (out_pc !== 64'h0) begin n_fail++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (stall_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    endtask

    task automatic test_single_push();
        in_valid = 1'b1; in_pc = 64'h80000000; in_inst = 32'h00000297; out_ready = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got %0b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got %0b want 1", out_valid); end
        n_checks++; if (out_pc !== 64'h80000000) begin n_fail++; $display("FAIL single_out_pc got %h want 80000000", out_pc); end
        n_checks++; if (out_inst !== 32'h00000297) begin n_fail++; $display("FAIL single_out_inst got %h want 00000297", out_inst); end
        n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL single_drain_count got %0d want 0", count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_fill_stall();
        push2(64'h80000000, 32'h00000297, 64'h80000004, 32'h00000513);
        n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL fill_count got %0d want 2", count); end
        in_valid = 1'b1; in_pc = 64'h80000008; in_inst = 32'h00100073;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %0b want 0", in_ready); end
        tick(); tick(); tick();
        in_valid = 1'b0;
        n_checks++; if (stall_cnt !== 64'd3) begin n_fail++; $display("FAIL fill_stall_cnt got %0d want 3", stall_cnt); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (out_pc !== 64'h80000000) begin n_fail++; $display("FAIL fill_pop0 got %h want 80000000", out_pc); end
        tick();
        n_checks++; if (out_pc !== 64'h80000004) begin n_fail++; $display("FAIL fill_pop1 got %h want 80000004", out_pc); end
        n_checks++; if (out_inst !== 32'h00000513) begin n_fail++; $display("FAIL fill_pop1_inst got %h want 00000513", out_inst); end
        tick();
        out_ready = 1'b0;
        n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL fill_empty_count got %0d want 0", count); end
    endtask

    task automatic test_full_pop_push();
        push2(64'h80000010, 32'h00000011, 64'h80000014, 32'h00000022);
        in_valid = 1'b1; in_pc = 64'h80000018; in_inst = 32'h00000033; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fullpp_in_ready got %0b want 0", in_ready); end
        tick();
        n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL fullpp_count_after_pop got %0d want 1", count); end
        n_checks++; if (out_pc !== 64'h80000014) begin n_fail++; $display("FAIL fullpp_head got %h want 80000014", out_pc); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpp_in_ready_after got %0b want 1", in_ready); end
        tick();
        n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL fullpp_count_pushpop got %0d want 1", count); end
        n_checks++; if (out_pc !== 64'h80000018) begin n_fail++; $display("FAIL fullpp_head2 got %h want 80000018", out_pc); end
        n_checks++; if (out_inst !== 32'h00000033) begin n_fail++; $display("FAIL fullpp_head2_inst got %h want 00000033", out_inst); end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL fullpp_drain got %0d want 0", count); end
        n_checks++; if (stall_cnt !== 64'd4) begin n_fail++; $display("FAIL fullpp_stall_cnt got %0d want 4", stall_cnt); end
    endtask

    task automatic test_flush();
        push2(64'h80000020, 32'h00000044, 64'h80000024, 32'h00000055);
        in_valid = 1'b1; in_pc = 64'h80000028; in_inst = 32'h00000066; out_ready = 1'b1; flush = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %0b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
        n_checks++; if (out_inst !== 32'h00000013) begin n_fail++; $display("FAIL flush_out_inst got %h want 00000013", out_inst); end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
        n_checks++; if (out_inst !== 32'h00000013) begin n_fail++; $display("FAIL flush_after_inst got %h want 00000013", out_inst); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after_valid got %0b want 0", out_valid); end
        n_checks++; if (stall_cnt !== 64'd5) begin n_fail++; $display("FAIL flush_stall_cnt got %0d want 5", stall_cnt); end
        in_valid = 1'b1; in_pc = 64'h80000100; in_inst = 32'h00100073;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_pc !== 64'h80000100) begin n_fail++; $display("FAIL flush_repush_pc got %h want 80000100", out_pc); end
        n_checks++; if (out_inst !== 32'h00100073) begin n_fail++; $display("FAIL flush_repush_inst got %h want 00100073", out_inst); end
        n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL flush_repush_count got %0d want 1", count); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_pc = 64'h80000200; in_inst = 32'h00000077;
        tick();
        in_valid = 1'b0;
        n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL arst_pre_count got %0d want 2", count); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got %0b want 0", out_valid); end
        n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL arst_count got %0d want 0", count); end
        n_checks++; if (stall_cnt !== 64'd0) begin n_fail++; $display("FAIL arst_stall_cnt got %0d want 0", stall_cnt); end
        n_checks++; if (out_inst !== 32'h00000013) begin n_fail++; $display("FAIL arst_out_inst got %h want 00000013", out_inst); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready got %0b want 1", in_ready); end
        n_checks++; if (out_pc !== 64'h0) begin n_fail++; $display("FAIL arst_out_pc got %h want 0", out_pc); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_stall();
        test_full_pop_push();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout reached at %0t without finishing", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_ysyx_22041207_ifid_queue

// File: doc/ysyx_22041207_ifid_queue.md
# ysyx_22041207_ifid_queue

Show-ahead instruction queue between the instruction-fetch stage and the decode stage of the ysyx_22041207 RV64 core. It captures fetched {pc, inst} pairs and presents the oldest one to decode with a valid/ready handshake. Its inverted `in_ready` drives the fetch stage's `pc_delay` stall input. A synchronous flush discards all in-flight instructions on a control-flow redirect from EX.

## Interface
Parameters:
- `DEPTH`, 2, number of entries; power of two, 2..8.
- `XLEN`, 64, PC width.
- `ILEN`, 32, instruction width.

Ports:
- `clk`  in  1  single core clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  discard all entries this cycle (EX redirect: jal, jalr, taken branch).
- `in_valid`  in  1  fetch presents a valid pair.
- `in_ready`  out  1  queue accepts; fetch uses `~in_ready` as `pc_delay`.
- `in_pc`  in  XLEN  PC of the fetched instruction.
- `in_inst`  in  ILEN  fetched instruction word.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  decode consumes the head.
- `out_pc`  out  XLEN  head PC.
- `out_inst`  out  ILEN  head instruction.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `stall_cnt`  out  64  number of cycles with `in_valid && !in_ready`.

## Operation
- Push condition: `in_valid && in_ready`. Pop condition: `out_valid && out_ready`.
- `in_ready = (count < DEPTH) && !flush`. This signal is independent of `out_ready`, so a full queue never accepts, even when a pop happens in the same cycle.
- `out_valid = (count != 0) && !flush`.
- When `out_valid` is low, `out_pc = 0` and `out_inst = 32'h00000013` (NOP). Otherwise both reflect the head entry.
- Storage: circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH naturally. `count` is tracked separately so full and empty are unambiguous.
- Push only: write the entry at `wr_ptr`, advance `wr_ptr`, `count+1`.
- Pop only: advance `rd_ptr`, `count-1`.
- Push and pop together: both pointers advance and `count` is unchanged. This is legal at any occupancy from 1 to DEPTH-1.
- Flush: at the next edge, `wr_ptr = rd_ptr = 0` and `count = 0`. Any push or pop offered in the flush cycle is ignored, because both handshakes are already masked by `flush`. Entry contents are not cleared.
- `stall_cnt` increments by 1 in every cycle where `in_valid && !in_ready`, including flush cycles. It wraps at 2^64. It is not cleared by flush.
- Reset (async, any time, including mid-transfer): pointers = 0, `count` = 0, all entries = {0, NOP}, `stall_cnt` = 0.
  - Resulting outputs: `out_valid` = 0, `out_pc` = 0, `out_inst` = 32'h00000013.
  - `in_ready` = 1 (0 if `flush` is high).
- No state machine. State is the pointers, `count`, storage and `stall_cnt`.

## Timing
- Push-to-visible latency is 1 cycle: a pair accepted at edge N drives `out_valid` during the cycle after N. There is no combinational bypass when the queue is empty.
- Outputs are combinational only from registered state plus `flush`. No path exists from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.
- Throughput is 1 instruction/cycle in steady state when DEPTH ≥ 2 and decode is always ready.
- Flush takes effect at the asserting edge. The first post-flush push is accepted in the cycle after flush deasserts.
- The `rst` assertion effect is immediate (asynchronous). Deassertion is assumed synchronised to `clk` upstream.

## Structure
- Shared package `ysyx_22041207_pkg` holds:
  - `XLEN` = 64 and `ILEN` = 32;
  - `NOP_INST` = 32'h00000013;
  - `RESET_PC` = 64'h80000000;
  - typedef `fetch_pkt_t` = {pc[XLEN-1:0], inst[ILEN-1:0]}.
- No sub-module. Storage is an inline array of `fetch_pkt_t`. The block is expected to be roughly 150 lines of RTL.

## Test plan
- Reset, then idle. Required: `out_valid`=0, `out_inst`=00000013, `out_pc`=0, `in_ready`=1, `count`=0, `stall_cnt`=0.
- Push pc 80000000/inst 00000297 with `out_ready`=0. Required: `out_valid`=1 the next cycle, `out_pc`=80000000, `count`=1.
- DEPTH=2, `out_ready`=0, push 80000000, 80000004, then offer 80000008. Required: `in_ready`=0 at `count`=2. Holding `in_valid` 3 cycles gives `stall_cnt`=3. Raise `out_ready`: pops return 80000000 then 80000004, in order.
- Full queue, `out_ready`=1 and `in_valid`=1 in the same cycle. Required: pop occurs, push is refused, `count` goes 2→1. The next cycle, push is accepted and `count` stays 1.
- Queue holding 2 entries, assert `flush` with `in_valid`=1 and `out_ready`=1. Required: same-cycle `out_valid`=0 and `in_ready`=0. After the edge, `count`=0 and `out_inst`=00000013. The next push of 80000100 appears at the head.
- Assert `rst` asynchronously between edges with `count`=2. Required: `out_valid` falls immediately, `count`=0, `stall_cnt`=0.
